mem_arbiter: RTL and testbench

- Shares the single main-memory port between I-cache line fills and D-cache line fills and write-backs.
- Sits below the F-stage and C-stage caches.
- Sequences each line transfer as a fixed-length burst of single-word beats.
- Round-robin fairness on ties, so dcache_stall cannot starve fetch and fetch cannot starve the data side.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter_burst_ctr.sv | 39 +++
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-memory port arbiter: FSM encoding,
// requester identities and default geometry.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    IC = 1'b0,
    DC = 1'b1
  } req_id_t;

  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter; master is the arbiter's
// view, slave is the view of the caches plus memory around it.
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W
);
  localparam int BW = $clog2(LINE_WORDS);

  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_gnt;
  logic              ic_rvalid;
  logic              ic_done;
  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic              dc_gnt;
  logic              dc_rvalid;
  logic              dc_wready;
  logic              dc_done;
  logic [BW-1:0]     beat_idx;
  logic [DATA_W-1:0] rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ack, mem_rdata,
    output ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_wready, dc_done,
    output beat_idx, rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ack, mem_rdata,
    input  ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_wready, dc_done,
    input  beat_idx, rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_burst_ctr.sv
// Line base register and beat counter for one burst; load on grant,
// step on each acked beat, flag the last beat of the line.
module mem_burst_ctr #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          load,
  input  logic [ADDR_W-1:0]             load_addr,
  input  logic                          inc,
  output logic [$clog2(LINE_WORDS)-1:0] beat,
  output logic                          last,
  output logic [ADDR_W-1:0]             addr
);
  localparam int BW = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(LINE_WORDS * 4 - 1);

  logic [ADDR_W-1:0] base_q;
  logic [BW-1:0]     beat_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_q <= '0;
      beat_q <= '0;
    end else if (load) begin
      base_q <= load_addr & ~OFS_MASK;
      beat_q <= '0;
    end else if (inc) begin
      // Wraps to zero on the last beat; the owner leaves BUSY on that ack.
      beat_q <= beat_q + 1'b1;
    end
  end

  assign beat = beat_q;
  assign last = (beat_q == BW'(LINE_WORDS - 1));
  assign addr = base_q | (ADDR_W'(beat_q) << 2);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting the single memory port to I-cache fills or
// D-cache fills/write-backs as fixed LINE_WORDS-beat bursts, one turnaround cycle between bursts.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.master bus
);
  localparam int BW = $clog2(LINE_WORDS);

  arb_state_t        state_q, state_d;
  req_id_t           last_served_q;
  logic              we_q;
  logic              first_q;
  logic              grant_i, grant_d;
  logic              load;
  logic              beat_inc;
  logic              beat_last;
  logic [BW-1:0]     beat;
  logic [ADDR_W-1:0] line_addr;
  logic [ADDR_W-1:0] beat_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_served_q <= IC;
      we_q          <= 1'b0;
      first_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= load;
      if (grant_i) begin
        last_served_q <= IC;
        we_q          <= 1'b0;
      end else if (grant_d) begin
        last_served_q <= DC;
        we_q          <= bus.dc_we;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_i       = 1'b0;
    grant_d       = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.ic_gnt    = 1'b0;
    bus.ic_rvalid = 1'b0;
    bus.ic_done   = 1'b0;
    bus.dc_gnt    = 1'b0;
    bus.dc_rvalid = 1'b0;
    bus.dc_wready = 1'b0;
    bus.dc_done   = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the side that was not served last wins.
        if (bus.dc_req && (!bus.ic_req || last_served_q == IC)) begin
          grant_d = 1'b1;
          state_d = BUSY_D;
        end else if (bus.ic_req) begin
          grant_i = 1'b1;
          state_d = BUSY_I;
        end
      end
      BUSY_I: begin
        bus.mem_req   = 1'b1;
        bus.mem_addr  = beat_addr;
        bus.ic_gnt    = first_q;
        bus.ic_rvalid = bus.mem_ack;
        bus.ic_done   = bus.mem_ack & beat_last;
        if (bus.mem_ack && beat_last) state_d = IDLE;
      end
      BUSY_D: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = beat_addr;
        bus.mem_wdata = we_q ? bus.dc_wdata : '0;
        bus.dc_gnt    = first_q;
        bus.dc_rvalid = bus.mem_ack & ~we_q;
        bus.dc_wready = bus.mem_ack & we_q;
        bus.dc_done   = bus.mem_ack & beat_last;
        if (bus.mem_ack && beat_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign load         = grant_i | grant_d;
  assign line_addr    = grant_d ? bus.dc_addr : bus.ic_addr;
  assign beat_inc     = (state_q != IDLE) & bus.mem_ack;
  assign bus.beat_idx = beat;
  assign bus.rdata    = bus.mem_rdata;

  mem_burst_ctr #(
    .LINE_WORDS(LINE_WORDS),
    .ADDR_W    (ADDR_W)
  ) u_burst_ctr (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .load_addr(line_addr),
    .inc      (beat_inc),
    .beat     (beat),
    .last     (beat_last),
    .addr     (beat_addr)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected beats are queued when requests are
// raised and checked against each memory beat the arbiter issues.
module tb_mem_arbiter;
  localparam int LW = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_arbiter_if #(.LINE_WORDS(LW), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic          owner;  // 0 = I-cache, 1 = D-cache
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            beat;
    logic          last;
  } beat_t;

  typedef struct {
    logic owner;
    int   gap;
  } gnt_t;

  beat_t         sb[$];
  gnt_t          gnt_log[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            ack_period = 1;
  int            ack_cnt = 0;
  int            last_done_cyc = -100;
  int            ic_left = 0, dc_left = 0;
  int            ic_rv, dc_rv, dc_wr, ic_gnt_n, dc_gnt_n;
  int            ic_gnt_cyc, dc_gnt_cyc, ic_done_cyc, dc_done_cyc;
  int            req_cyc;
  logic          stray_ack = 1'b0;
  logic [DW-1:0] rd_val;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    ic_rv = 0; dc_rv = 0; dc_wr = 0; ic_gnt_n = 0; dc_gnt_n = 0;
    ic_gnt_cyc = -1; dc_gnt_cyc = -1; ic_done_cyc = -1; dc_done_cyc = -1;
    ack_cnt = 0;
    gnt_log.delete();
  endtask

  task automatic push_line(input logic owner, input logic we, input logic [AW-1:0] addr);
    for (int k = 0; k < LW; k++)
      sb.push_back('{owner, we, (addr & ~32'hF) + AW'(4 * k), 32'hD000_0000 | DW'(k), k, (k == LW - 1)});
  endtask

  task automatic observe();
    beat_t      e;
    logic [4:0] pulses;
    pulses = {bus.ic_rvalid, bus.dc_rvalid, bus.dc_wready, bus.ic_done, bus.dc_done};
    if (bus.ic_gnt || bus.dc_gnt) gnt_log.push_back('{bus.dc_gnt, cyc - last_done_cyc});
    if (bus.ic_gnt) begin ic_gnt_n++; ic_gnt_cyc = cyc; end
    if (bus.dc_gnt) begin dc_gnt_n++; dc_gnt_cyc = cyc; end
    if (bus.ic_done) ic_done_cyc = cyc;
    if (bus.dc_done) dc_done_cyc = cyc;
    if (bus.ic_rvalid) ic_rv++;
    if (bus.dc_rvalid) dc_rv++;
    if (bus.dc_wready) dc_wr++;
    if (!bus.mem_req) begin
      check("idle_pulses", {pulses, bus.ic_gnt, bus.dc_gnt}, 0);
      check("idle_we_addr", {bus.mem_we, bus.mem_addr}, 0);
    end else if (sb.size() == 0) begin
      check("unexpected_mem_req", bus.mem_req, 0);
    end else begin
      e = sb[0];
      check("mem_addr", bus.mem_addr, e.addr);
      check("mem_we", bus.mem_we, e.we);
      check("beat_idx", bus.beat_idx, e.beat);
      check("mem_wdata", bus.mem_wdata, e.we ? e.wdata : '0);
      check("gnt_side", {bus.ic_gnt & e.owner, bus.dc_gnt & ~e.owner}, 0);
      if (bus.mem_ack) begin
        check("beat_pulses", pulses,
              {~e.owner, e.owner & ~e.we, e.owner & e.we, ~e.owner & e.last, e.owner & e.last});
        check("rdata", bus.rdata, rd_val);
        void'(sb.pop_front());
        if (e.last) begin
          last_done_cyc = cyc;
          if (!e.owner) begin
            ic_left--;
            if (ic_left == 0) bus.ic_req = 1'b0;
          end else begin
            dc_left--;
            if (dc_left == 0) begin bus.dc_req = 1'b0; bus.dc_we = 1'b0; end
          end
        end
      end else begin
        check("wait_pulses", pulses, 0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    bus.dc_wdata = 32'hD000_0000 | DW'(bus.beat_idx);
    if (bus.mem_req) begin
      ack_cnt++;
      bus.mem_ack = ((ack_cnt % ack_period) == 0);
    end else begin
      bus.mem_ack = stray_ack;
    end
    rd_val = $urandom;
    bus.mem_rdata = rd_val;
    #1;
    observe();
  endtask

  task automatic run_until_quiet(input string tag, input int max);
    int n = 0;
    while ((sb.size() != 0 || bus.ic_req || bus.dc_req) && n < max) begin
      tick();
      n++;
    end
    check({tag, "_completes"}, {sb.size() == 0, bus.ic_req, bus.dc_req}, 3'b100);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.ic_req = 1'b0; bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.mem_ack = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    sb.delete();
    ic_left = 0; dc_left = 0; last_done_cyc = -100;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.ic_req = 1'b0; bus.ic_addr = '0;
    bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.dc_addr = '0; bus.dc_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    clear_stats();
    repeat (2) @(posedge clock);
    #2;
    check("rst_ctrl", {bus.mem_req, bus.mem_we, bus.ic_gnt, bus.dc_gnt, bus.ic_done, bus.dc_done}, 0);
    check("rst_valid", {bus.ic_rvalid, bus.dc_rvalid, bus.dc_wready}, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_beat_idx", bus.beat_idx, 0);
    reset = 1'b0;

    // Stray acks while idle straight after reset.
    stray_ack = 1'b1;
    repeat (3) tick();
    check("stray_beat_idx", bus.beat_idx, 0);
    check("stray_no_pulses", ic_rv + dc_rv + dc_wr + ic_gnt_n + dc_gnt_n, 0);
    stray_ack = 1'b0;

    // I-only fill, zero-wait memory.
    clear_stats();
    ack_period = 1;
    bus.ic_addr = 32'h0000_104C;
    push_line(1'b0, 1'b0, 32'h0000_104C);
    ic_left = 1;
    req_cyc = cyc;
    bus.ic_req = 1'b1;
    run_until_quiet("i_fill", 40);
    check("i_gnt_count", ic_gnt_n, 1);
    check("i_gnt_latency", ic_gnt_cyc - req_cyc, 1);
    check("i_done_latency", ic_done_cyc - ic_gnt_cyc, LW - 1);
    check("i_rvalid_count", ic_rv, LW);
    check("i_dc_quiet", dc_rv + dc_wr + dc_gnt_n, 0);

    // D write-back, memory acks every third cycle.
    tick();
    clear_stats();
    ack_period = 3;
    bus.dc_addr = 32'h0000_2000;
    bus.dc_we = 1'b1;
    push_line(1'b1, 1'b1, 32'h0000_2000);
    dc_left = 1;
    bus.dc_req = 1'b1;
    run_until_quiet("d_wb", 80);
    check("d_wready_count", dc_wr, LW);
    check("d_no_rvalid", dc_rv, 0);
    check("d_wb_duration", dc_done_cyc - dc_gnt_cyc, 3 * LW - 1);
    check("d_ic_quiet", ic_rv + ic_gnt_n, 0);

    // Tie after reset: D first, D re-requests, I wins that tie, then D again.
    do_reset();
    clear_stats();
    ack_period = 1;
    bus.ic_addr = 32'h0000_1040;
    bus.dc_addr = 32'h0000_2000;
    bus.dc_we = 1'b0;
    push_line(1'b1, 1'b0, 32'h0000_2000);
    push_line(1'b0, 1'b0, 32'h0000_1040);
    push_line(1'b1, 1'b0, 32'h0000_2000);
    ic_left = 1;
    dc_left = 2;
    bus.ic_req = 1'b1;
    bus.dc_req = 1'b1;
    run_until_quiet("tie", 80);
    check("tie_gnt_count", gnt_log.size(), 3);
    if (gnt_log.size() >= 3) begin
      check("tie_order", {gnt_log[0].owner, gnt_log[1].owner, gnt_log[2].owner}, 3'b101);
      check("tie_i_gap", gnt_log[1].gap, 2);
      check("tie_d_gap", gnt_log[2].gap, 2);
    end

    // Contention: I request arrives during a D read burst.
    tick();
    clear_stats();
    ack_period = 2;
    bus.dc_addr = 32'h0000_2000;
    bus.dc_we = 1'b0;
    push_line(1'b1, 1'b0, 32'h0000_2000);
    dc_left = 1;
    bus.dc_req = 1'b1;
    repeat (3) tick();
    bus.ic_addr = 32'h0000_1044;
    push_line(1'b0, 1'b0, 32'h0000_1044);
    ic_left = 1;
    bus.ic_req = 1'b1;
    run_until_quiet("contend", 80);
    check("contend_i_after_d", ic_gnt_cyc - dc_done_cyc, 2);
    check("contend_d_rvalid", dc_rv, LW);

    // Reset during an I burst, after its second ack.
    tick();
    clear_stats();
    ack_period = 1;
    bus.ic_addr = 32'h0000_1040;
    push_line(1'b0, 1'b0, 32'h0000_1040);
    ic_left = 1;
    bus.ic_req = 1'b1;
    for (int n = 0; n < 20 && ic_rv < 2; n++) tick();
    check("mid_two_acks", ic_rv, 2);
    @(posedge clock);
    #1;
    check("pre_reset_busy", {bus.mem_req, bus.beat_idx}, {1'b1, 2'd2});
    bus.mem_ack = 1'b1;
    reset = 1'b1;
    #1;
    check("mid_rst_mem_req", bus.mem_req, 0);
    check("mid_rst_ic_rvalid", {bus.ic_rvalid, bus.ic_done}, 0);
    check("mid_rst_beat_idx", bus.beat_idx, 0);
    check("mid_rst_mem_addr", bus.mem_addr, 0);
    sb.delete();
    push_line(1'b0, 1'b0, 32'h0000_1040);
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.mem_ack = 1'b0;
    clear_stats();
    run_until_quiet("restart", 40);
    check("restart_rvalid", ic_rv, LW);
    check("restart_gnt", ic_gnt_n, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
